// File: rtl/knn_fetch_ctrl.sv
// KNN fetch controller: streams input/training element pairs to a distance datapath and writes back results.
// Optional read watchdog enabled by defining KNN_FETCH_TIMEOUT_EN.
module knn_fetch_ctrl #(
  parameter int W           = 32,
  parameter int TYPE_W      = 4,
  parameter int ELEMS       = 16,
  parameter int L           = 8,
  parameter int NUM_INF     = 4,
  parameter int ADDR_W      = 16,
  parameter int BASE_T_ADDR = 0,
  parameter int BASE_I_ADDR = 1024,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              read,
  output logic [ADDR_W-1:0] readaddress,
  input  logic [W-1:0]      readdata,
  input  logic              readdatavalid,
  output logic              write,
  output logic [ADDR_W-1:0] writeaddress,
  output logic [W-1:0]      writedata,
  input  logic              waitrequest,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic [W-1:0]      pair_in,
  output logic [W-1:0]      pair_tr,
  output logic              pair_last,
  output logic [TYPE_W-1:0] sample_type,
  input  logic [TYPE_W-1:0] inferred_type,
  input  logic              inference_done
);

  localparam int EW  = (ELEMS   > 1) ? $clog2(ELEMS)     : 1;
  localparam int TW  = (L       > 1) ? $clog2(L)         : 1;
  localparam int NW  = (NUM_INF > 1) ? $clog2(NUM_INF)   : 1;
  localparam int TMW = (TIMEOUT > 1) ? $clog2(TIMEOUT+1) : 1;
  localparam logic [EW-1:0]     E_LAST = EW'(ELEMS-1);
  localparam logic [TW-1:0]     T_LAST = TW'(L-1);
  localparam logic [NW-1:0]     N_LAST = NW'(NUM_INF-1);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ELEMS+1);
  localparam logic [TMW-1:0]    TMO_LAST = TMW'(TIMEOUT-1);
`ifdef KNN_FETCH_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, LD_IN, TR_TYPE, TR_ELEM, PAIR, WAIT_INF, WR_RES
  } state_t;

  state_t              r_state, w_next;
  logic                r_pend, r_read, r_done, r_err;
  logic [ADDR_W-1:0]   r_raddr, r_ibase, r_tbase, r_waddr, w_addr;
  logic [W-1:0]        r_buf [ELEMS];
  logic [W-1:0]        r_pin, r_ptr, r_wdata;
  logic                r_pvalid, r_plast, r_write;
  logic [TYPE_W-1:0]   r_stype;
  logic [EW-1:0]       r_e;
  logic [TW-1:0]       r_t;
  logic [NW-1:0]       r_n;
  logic [TMW-1:0]      r_tmo;
  logic                w_rdv, w_rd_state, w_tmo;

  // Completions only count while a read is pending; stray strobes are dropped.
  assign w_rdv      = readdatavalid & r_pend;
  assign w_rd_state = (r_state == LD_IN) || (r_state == TR_TYPE) || (r_state == TR_ELEM);
  assign w_tmo      = TMO_EN && r_pend && !readdatavalid && (r_tmo == TMO_LAST);

  always_comb begin
    w_addr = '0;
    unique case (r_state)
      LD_IN:   w_addr = r_ibase + ADDR_W'(1) + ADDR_W'(r_e);
      TR_TYPE: w_addr = r_tbase;
      TR_ELEM: w_addr = r_tbase + ADDR_W'(1) + ADDR_W'(r_e);
      default: w_addr = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (start) w_next = LD_IN;
      LD_IN:    if (w_rdv && (r_e == E_LAST)) w_next = TR_TYPE;
      TR_TYPE:  if (w_rdv) w_next = TR_ELEM;
      TR_ELEM:  if (w_rdv) w_next = PAIR;
      PAIR:     if (pair_ready)
                  w_next = (r_e != E_LAST) ? TR_ELEM :
                           (r_t == T_LAST) ? WAIT_INF : TR_TYPE;
      WAIT_INF: if (inference_done) w_next = WR_RES;
      WR_RES:   if (!waitrequest) w_next = (r_n == N_LAST) ? IDLE : LD_IN;
      default:  w_next = IDLE;
    endcase
    if (w_tmo) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pend   <= 1'b0;
      r_read   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_raddr  <= '0;
      r_ibase  <= '0;
      r_tbase  <= '0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_pin    <= '0;
      r_ptr    <= '0;
      r_pvalid <= 1'b0;
      r_plast  <= 1'b0;
      r_stype  <= '0;
      r_e      <= '0;
      r_t      <= '0;
      r_n      <= '0;
      r_tmo    <= '0;
      for (int unsigned i = 0; i < ELEMS; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_next;
      r_read  <= 1'b0;
      r_done  <= 1'b0;
      if (r_pend && !readdatavalid) r_tmo <= r_tmo + TMW'(1);
      else                          r_tmo <= '0;

      if (w_tmo) begin
        r_pend <= 1'b0;
        r_err  <= 1'b1;
      end else if (w_rdv) begin
        r_pend <= 1'b0;
      end else if (w_rd_state && !r_pend) begin
        r_read  <= 1'b1;
        r_pend  <= 1'b1;
        r_raddr <= w_addr;
      end

      unique case (r_state)
        IDLE: if (start) begin
          r_err   <= 1'b0;
          r_n     <= '0;
          r_e     <= '0;
          r_ibase <= ADDR_W'(BASE_I_ADDR);
        end
        LD_IN: if (w_rdv) begin
          r_buf[r_e] <= readdata;
          if (r_e == E_LAST) begin
            r_e     <= '0;
            r_t     <= '0;
            r_tbase <= ADDR_W'(BASE_T_ADDR);
          end else begin
            r_e <= r_e + EW'(1);
          end
        end
        TR_TYPE: if (w_rdv) begin
          r_stype <= readdata[TYPE_W-1:0];
          r_e     <= '0;
        end
        TR_ELEM: if (w_rdv) begin
          r_ptr    <= readdata;
          r_pin    <= r_buf[r_e];
          r_plast  <= (r_e == E_LAST);
          r_pvalid <= 1'b1;
        end
        PAIR: if (pair_ready) begin
          r_pvalid <= 1'b0;
          if (r_e == E_LAST) begin
            r_e     <= '0;
            r_t     <= r_t + TW'(1);
            r_tbase <= r_tbase + STRIDE;
          end else begin
            r_e <= r_e + EW'(1);
          end
        end
        WAIT_INF: if (inference_done) begin
          r_waddr <= r_ibase;
          r_wdata <= W'(inferred_type);
          r_write <= 1'b1;
        end
        WR_RES: if (!waitrequest) begin
          r_write <= 1'b0;
          r_e     <= '0;
          r_n     <= r_n + NW'(1);
          r_ibase <= r_ibase + STRIDE;
          if (r_n == N_LAST) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign err          = r_err;
  assign read         = r_read;
  assign readaddress  = r_raddr;
  assign write        = r_write;
  assign writeaddress = r_waddr;
  assign writedata    = r_wdata;
  assign pair_valid   = r_pvalid;
  assign pair_in      = r_pin;
  assign pair_tr      = r_ptr;
  assign pair_last    = r_plast;
  assign sample_type  = r_stype;

endmodule

// File: tb/tb_knn_fetch_ctrl.sv
// Directed self-checking bench for knn_fetch_ctrl: ELEMS=4, L=2, NUM_INF=2, 1-cycle memory model.
module tb_knn_fetch_ctrl;
  localparam int W = 32, TYPE_W = 4, ELEMS = 4, L = 2, NUM_INF = 2, ADDR_W = 16;
  localparam int BT = 0, BI = 1024, STR = ELEMS + 1;

  logic              clk, rst_n, start, busy, done, err;
  logic              read, readdatavalid, write, waitrequest;
  logic [ADDR_W-1:0] readaddress, writeaddress;
  logic [W-1:0]      readdata, writedata, pair_in, pair_tr;
  logic              pair_valid, pair_ready, pair_last, inference_done;
  logic [TYPE_W-1:0] sample_type, inferred_type;

  int n_checks = 0, n_fail = 0;

  knn_fetch_ctrl #(.W(W), .TYPE_W(TYPE_W), .ELEMS(ELEMS), .L(L), .NUM_INF(NUM_INF),
                   .ADDR_W(ADDR_W), .BASE_T_ADDR(BT), .BASE_I_ADDR(BI), .TIMEOUT(40)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .read(read), .readaddress(readaddress), .readdata(readdata), .readdatavalid(readdatavalid),
    .write(write), .writeaddress(writeaddress), .writedata(writedata), .waitrequest(waitrequest),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .pair_in(pair_in), .pair_tr(pair_tr),
    .pair_last(pair_last), .sample_type(sample_type), .inferred_type(inferred_type),
    .inference_done(inference_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory model: one-cycle read latency, optional response suppression.
  logic [31:0] mem [0:2047];
  logic        suppress = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdatavalid <= 1'b0;
      readdata      <= '0;
    end else begin
      readdatavalid <= read & ~suppress;
      if (read) readdata <= mem[readaddress[10:0]];
    end
  end

  // Read monitor: address log plus protocol violations.
  logic [15:0] rd_log [0:255];
  int   rcnt = 0, rd_viol = 0;
  logic rd_pend_m = 1'b0, prev_read = 1'b0;
  always @(posedge clk) begin
    if (read) begin
      rd_log[rcnt] <= readaddress;
      rcnt <= rcnt + 1;
      if (rd_pend_m || prev_read) rd_viol <= rd_viol + 1;
    end
    prev_read <= read;
    if (read) rd_pend_m <= 1'b1;
    else if (readdatavalid || !rst_n || suppress) rd_pend_m <= 1'b0;
  end

  // Pair monitor.
  logic [31:0] p_in [0:63], p_tr [0:63];
  logic        p_last [0:63];
  logic [3:0]  p_ty [0:63];
  int pcnt = 0;
  always @(posedge clk) begin
    if (pair_valid && pair_ready) begin
      p_in[pcnt]   <= pair_in;
      p_tr[pcnt]   <= pair_tr;
      p_last[pcnt] <= pair_last;
      p_ty[pcnt]   <= sample_type;
      pcnt <= pcnt + 1;
    end
  end

  // Write slave: stalls each write for wr_stall cycles.
  logic [15:0] w_addr [0:7];
  logic [31:0] w_data [0:7];
  int w_hold [0:7];
  int wcnt = 0, wn = 0, wr_stall = 3, dcnt = 0;
  assign waitrequest = write && (wcnt < wr_stall);
  always @(posedge clk) begin
    if (write) begin
      if (waitrequest) wcnt <= wcnt + 1;
      else begin
        w_addr[wn] <= writeaddress;
        w_data[wn] <= writedata;
        w_hold[wn] <= wcnt + 1;
        wn   <= wn + 1;
        wcnt <= 0;
      end
    end else wcnt <= 0;
    if (done) dcnt <= dcnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] elem_word(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_pairs(input int target);
    for (int k = 0; k < 400 && pcnt < target; k++) @(negedge clk);
    check_eq("pair_count", pcnt, target);
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 60 && !pair_valid; k++) @(negedge clk);
    check_eq("pair_valid_up", pair_valid, 1);
  endtask

  task automatic do_infer(input logic [3:0] ty);
    repeat (2) @(negedge clk);
    inferred_type  = ty;
    inference_done = 1'b1;
    @(negedge clk) inference_done = 1'b0;
  endtask

  task automatic wait_done(input int base);
    for (int k = 0; k < 100 && dcnt == base; k++) @(negedge clk);
    check_eq("busy_at_done", busy, 0);
    repeat (3) @(negedge clk);
    check_eq("done_pulses", dcnt - base, 1);
  endtask

  task automatic check_pairs(input int pb);
    for (int k = 0; k < 16; k++) begin
      int n, t, e;
      n = k / 8; t = (k % 8) / 4; e = k % 4;
      check_eq($sformatf("pin%0d", k), p_in[pb+k], elem_word(BI + n*STR + 1 + e));
      check_eq($sformatf("ptr%0d", k), p_tr[pb+k], elem_word(BT + t*STR + 1 + e));
      check_eq($sformatf("plast%0d", k), p_last[pb+k], (e == 3) ? 1 : 0);
      check_eq($sformatf("ptype%0d", k), p_ty[pb+k], (t == 0) ? 7 : 2);
    end
  endtask

  task automatic check_writes(input int wb, input int d0, input int d1);
    check_eq("wr_count", wn - wb, 2);
    check_eq("wr0_addr", w_addr[wb], BI);
    check_eq("wr0_data", w_data[wb], d0);
    check_eq("wr0_hold", w_hold[wb], 4);
    check_eq("wr1_addr", w_addr[wb+1], BI + STR);
    check_eq("wr1_data", w_data[wb+1], d1);
    check_eq("wr1_hold", w_hold[wb+1], 4);
  endtask

  int pb, rb, wb, db, r0;

  initial begin
    rst_n = 1'b0; start = 1'b0; pair_ready = 1'b1;
    inference_done = 1'b0; inferred_type = '0;
    for (int a = 0; a < 2048; a++) mem[a] = elem_word(a);
    mem[BT] = 32'd7;
    mem[BT + STR] = 32'd2;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_read", read, 0);
    check_eq("rst_write", write, 0);
    check_eq("rst_pvalid", pair_valid, 0);
    check_eq("rst_raddr", readaddress, 0);

    // Run 1: full two-record run with a mid-sample back-pressure window.
    pb = pcnt; rb = rcnt; wb = wn; db = dcnt;
    pulse_start();
    check_eq("run1_busy", busy, 1);
    wait_pairs(pb + 2);
    pair_ready = 1'b0;
    wait_valid();
    r0 = rcnt;
    for (int i = 0; i < 5; i++) begin
      start = (i == 0);
      @(negedge clk);
      check_eq("stall_pv", pair_valid, 1);
      check_eq("stall_pin", pair_in, elem_word(BI + 1 + 2));
      check_eq("stall_ptr", pair_tr, elem_word(BT + 1 + 2));
      check_eq("stall_plast", pair_last, 0);
    end
    start = 1'b0;
    check_eq("stall_no_read", rcnt - r0, 0);
    check_eq("stall_no_pair", pcnt - pb, 2);
    pair_ready = 1'b1;
    wait_pairs(pb + 8);
    do_infer(4'd3);
    wait_pairs(pb + 16);
    do_infer(4'd5);
    wait_done(db);
    check_eq("run1_err", err, 0);
    check_pairs(pb);
    check_writes(wb, 3, 5);
    check_eq("rd_first", rd_log[rb], BI + 1);
    check_eq("rd_in_last", rd_log[rb+3], BI + 4);
    check_eq("rd_type0", rd_log[rb+4], BT);
    check_eq("rd_t0e0", rd_log[rb+5], BT + 1);
    check_eq("rd_type1", rd_log[rb+9], BT + STR);
    check_eq("rd_rec1", rd_log[rb+14], BI + STR + 1);
    check_eq("rd_total", rcnt - rb, 28);

    // Run 2: reset while a pair is presented, then restart from record 0.
    pair_ready = 1'b0;
    pulse_start();
    wait_valid();
    rst_n = 1'b0;
    #1;
    check_eq("ar_busy", busy, 0);
    check_eq("ar_read", read, 0);
    check_eq("ar_write", write, 0);
    check_eq("ar_pvalid", pair_valid, 0);
    check_eq("ar_plast", pair_last, 0);
    check_eq("ar_pin", pair_in, 0);
    check_eq("ar_ptr", pair_tr, 0);
    check_eq("ar_stype", sample_type, 0);
    check_eq("ar_raddr", readaddress, 0);
    check_eq("ar_waddr", writeaddress, 0);
    check_eq("ar_wdata", writedata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pair_ready = 1'b1;
    @(negedge clk);
    pb = pcnt; rb = rcnt; wb = wn; db = dcnt;
    pulse_start();
    wait_pairs(pb + 8);
    do_infer(4'd4);
    wait_pairs(pb + 16);
    do_infer(4'd6);
    wait_done(db);
    check_eq("run2_rd_first", rd_log[rb], BI + 1);
    check_pairs(pb);
    check_writes(wb, 4, 6);
    check_eq("rd_protocol", rd_viol, 0);

`ifdef KNN_FETCH_TIMEOUT_EN
    db = dcnt;
    suppress = 1'b1;
    pulse_start();
    for (int k = 0; k < 100 && busy; k++) @(negedge clk);
    check_eq("tmo_busy", busy, 0);
    check_eq("tmo_err", err, 1);
    check_eq("tmo_no_done", dcnt - db, 0);
    suppress = 1'b0;
`else
    check_eq("err_const", err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/knn_fetch_ctrl.md
KNN_FETCH_CTRL -- requirements
Module: knn_fetch_ctrl

Interface
REQ-001 Parameter W, default 32: memory word width; W > TYPE_W.
REQ-002 Parameter TYPE_W, default 4: class-type field width.
REQ-003 Parameter ELEMS, default 16: elements per sample; ELEMS >= 1.
REQ-004 Parameter L, default 8: training samples per inference; L >= 1.
REQ-005 Parameter NUM_INF, default 4: input records classified per start; NUM_INF >= 1.
REQ-006 Parameter ADDR_W, default 16: word-address width.
REQ-007 Parameter BASE_T_ADDR, default 0: training region base word address.
REQ-008 Parameter BASE_I_ADDR, default 1024: input region base word address.
REQ-009 Parameter TIMEOUT, default 255: read-timeout cycles; used only under REQ-043.
REQ-010 clk  in  1  single clock; all state changes on rising edge.
REQ-011 rst_n  in  1  asynchronous, active-low reset.
REQ-012 start  in  1  begin a run; sampled only in IDLE.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse after last result write accepted.
REQ-015 err  out  1  read timeout flag, held until next start.
REQ-016 read  out  1  one-cycle read request.
REQ-017 readaddress  out  ADDR_W  read word address.
REQ-018 readdata  in  W  read data, valid with readdatavalid.
REQ-019 readdatavalid  in  1  read completion strobe.
REQ-020 write  out  1  write request, held while waitrequest high.
REQ-021 writeaddress  out  ADDR_W  result slot address.
REQ-022 writedata  out  W  zero-extended inferred type.
REQ-023 waitrequest  in  1  memory stalls write when high.
REQ-024 pair_valid  out  1  element pair available.
REQ-025 pair_ready  in  1  distance datapath accepts pair.
REQ-026 pair_in  out  W  input-sample element.
REQ-027 pair_tr  out  W  training-sample element, same index.
REQ-028 pair_last  out  1  high with pair of index ELEMS-1.
REQ-029 sample_type  out  TYPE_W  type of training sample being streamed.
REQ-030 inferred_type  in  TYPE_W  classification result.
REQ-031 inference_done  in  1  result strobe; sampled only in WAIT_INF.

Function
REQ-032 Layout: training sample t at BASE_T_ADDR+t*(ELEMS+1) = type word then ELEMS elements; input record n at BASE_I_ADDR+n*(ELEMS+1) = result slot then ELEMS elements; address arithmetic modulo 2^ADDR_W.
REQ-033 States: IDLE, LD_IN, TR_TYPE, TR_ELEM, PAIR, WAIT_INF, WR_RES; IDLE->LD_IN on start; start ignored while busy.
REQ-034 At most one read outstanding; read pulses one cycle, next read issued no earlier than cycle after readdatavalid; readdatavalid outside a pending read ignored.
REQ-035 LD_IN reads record n elements 0..ELEMS-1 into internal ELEMS-word buffer, then TR_TYPE with t=0.
REQ-036 TR_TYPE reads type word into sample_type (held for whole sample), then TR_ELEM e=0.
REQ-037 TR_ELEM reads element e; on readdatavalid go PAIR driving pair_tr=readdata, pair_in=buffer[e], pair_valid=1; outputs stable until pair_ready; on pair_ready&pair_valid, e+1 -> TR_ELEM, or if e=ELEMS-1: t+1 -> TR_TYPE, or if also t=L-1 -> WAIT_INF.
REQ-038 pair_ready asserted continuously yields one pair per read round trip; no pair is dropped or duplicated.
REQ-039 WAIT_INF on inference_done latches writeaddress = record n slot, writedata = {zeros, inferred_type}, enters WR_RES with write=1.
REQ-040 WR_RES completes on cycle write=1 and waitrequest=0; then n+1 -> LD_IN (training re-read from t=0), or if n=NUM_INF-1 pulse done, go IDLE.

Reset
REQ-041 rst_n low, any state: immediately IDLE; read, write, busy, done, err, pair_valid, pair_last = 0; readaddress, writeaddress, writedata, pair_in, pair_tr, sample_type, buffer, counters = 0; in-flight read discarded.

Configuration
REQ-042 Macro KNN_FETCH_TIMEOUT_EN selects read watchdog.
REQ-043 Defined: TIMEOUT cycles without readdatavalid after read sets err=1, goes IDLE, no done; err clears on next accepted start. Undefined: wait indefinitely, err constant 0.

Verification
REQ-044 ELEMS=4,L=2,NUM_INF=1, 1-cycle memory, pair_ready=1 -> 8 pairs, pair_last on 4th/8th, sample_type per sample, one write to BASE_I_ADDR, done pulse.
REQ-045 pair_ready low 5 cycles mid-sample -> pair_valid/pair_in/pair_tr stable, no new read issued.
REQ-046 NUM_INF=2, inferred_type 3 then 5 with waitrequest high 3 cycles -> writes 3 @BASE_I_ADDR, 5 @BASE_I_ADDR+ELEMS+1, write held 4 cycles each.
REQ-047 rst_n low during PAIR then start -> outputs zero, restart from record 0; with macro, suppress readdatavalid -> err=1 after TIMEOUT cycles, busy=0.
